// File: rtl/button_reader.sv
// ============================================================================
// Module   : button_reader
// Purpose  : Two-flop synchroniser plus stability-counter debouncer for a raw
//            board pin. Outputs a clean level, one-cycle RISE/FALL pulses and
//            an optional 8-bit press counter (macro BUTTON_READER_COUNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_reader #(
  parameter int CNT_WIDTH = 20,
  parameter int STABLE    = 600000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       I,
  output logic       O,
  output logic       RISE,
  output logic       FALL,
  output logic [7:0] COUNT
);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    SET_HI = 2'd1,
    HIGH   = 2'd2,
    SET_LO = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 o_nxt;
  logic                 rise_nxt;
  logic                 fall_nxt;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= LOW;
      cnt   <= '0;
      O     <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      s1    <= I;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      O     <= o_nxt;
      RISE  <= rise_nxt;
      FALL  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          state_nxt = SET_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      SET_HI: begin
        if (!s2) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nxt = SET_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      SET_LO: begin
        if (s2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
    // Level is registered from the next state so O never decodes state combinationally.
    o_nxt = (state_nxt == HIGH) || (state_nxt == SET_LO);
  end

`ifdef BUTTON_READER_COUNT_EN
  logic [7:0] press_cnt;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      press_cnt <= 8'h00;
    end else if (rise_nxt) begin
      press_cnt <= press_cnt + 8'h01;
    end
  end

  assign COUNT = press_cnt;
`else
  assign COUNT = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_reader.sv
// ============================================================================
// Module   : tb_button_reader
// Purpose  : Randomised self-checking bench for button_reader against a
//            run-length reference model (STABLE=4, CNT_WIDTH=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_reader;

  localparam int STABLE    = 4;
  localparam int CNT_WIDTH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b1;
  logic       o;
  logic       rise;
  logic       fall;
  logic [7:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  button_reader #(
    .CNT_WIDTH(CNT_WIDTH),
    .STABLE   (STABLE)
  ) dut (
    .CLK   (clk),
    .RESETN(rst_n),
    .I     (din),
    .O     (o),
    .RISE  (rise),
    .FALL  (fall),
    .COUNT (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the output flips once STABLE consecutive synchronised
  // samples disagree with it; any agreeing sample zeroes the run length.
  logic       m_s1, m_s2, m_o, m_rise, m_fall;
  int         m_run;
  logic [7:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_o = 0; m_rise = 0; m_fall = 0; m_run = 0; m_count = 0;
    end else begin
      m_run  = (m_s2 != m_o) ? m_run + 1 : 0;
      m_rise = 0;
      m_fall = 0;
      if (m_run == STABLE) begin
        m_o   = ~m_o;
        m_run = 0;
        if (m_o) begin
          m_rise = 1;
`ifdef BUTTON_READER_COUNT_EN
          m_count = m_count + 8'd1;
`endif
        end else begin
          m_fall = 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = din;
    end
  end

  int rise_seen = 0;
  int fall_seen = 0;

  always @(posedge clk) begin
    #1;
    check("level", o, m_o);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("count", count, m_count);
    check("exclusive", rise & fall, 0);
    if (rise) rise_seen++;
    if (fall) fall_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges from the next posedge until the chosen pulse appears (bounded).
  task automatic wait_pulse(input bit want_rise, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #2;
      edges++;
    end while (!(want_rise ? rise : fall) && edges < 30);
  endtask

  initial begin
    int e;
    int r0, f0;
    logic [7:0] c0;
    bit pattern [6] = '{1, 0, 1, 1, 0, 1};

    // Reset held with pin high
    din = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("reset_o", o, 0);
    din = 1'b0;
    rst_n = 1'b1;
    tick(6);

    // Clean press
    din = 1'b1;
    wait_pulse(1'b1, e);
    check("press_latency", e, 6);
    check("press_o", o, 1);
    @(posedge clk); #2;
    check("press_width", rise, 0);
    tick(3);

    // Release back to low
    din = 1'b0;
    wait_pulse(1'b0, e);
    check("release_latency", e, 6);
    tick(3);

    // Short glitch
    r0 = rise_seen;
    din = 1'b1;
    tick(3);
    din = 1'b0;
    tick(10);
    check("glitch_rises", rise_seen - r0, 0);
    check("glitch_o", o, 0);

    // Bouncy press
    r0 = rise_seen;
    for (int i = 0; i < 5; i++) begin
      din = pattern[i];
      tick(1);
    end
    din = pattern[5];
    wait_pulse(1'b1, e);
    check("bouncy_latency", e, 6);
    tick(10);
    check("bouncy_rises", rise_seen - r0, 1);
    din = 1'b0;
    tick(10);

    // Press/release pairs with counter wrap
    r0 = rise_seen;
    f0 = fall_seen;
    c0 = m_count;
    for (int p = 0; p < 256; p++) begin
      din = 1'b1;
      wait_pulse(1'b1, e);
      if (p < 4) check("pair_rise_latency", e, 6);
      tick(1 + (p % 3));
      din = 1'b0;
      wait_pulse(1'b0, e);
      check("pair_fall_latency", e, 6);
      tick(1 + (p % 2));
    end
    tick(4);
    check("pair_rises", rise_seen - r0, 256);
    check("pair_falls", fall_seen - f0, 256);
`ifdef BUTTON_READER_COUNT_EN
    check("pair_wrap", count, c0);
`else
    check("pair_count_tied", count, 0);
`endif

    // Reset during a settle, pin stays high across release
    r0 = rise_seen;
    din = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_o", o, 0);
    check("midreset_rise", rise, 0);
    tick(2);
    check("midreset_rises", rise_seen - r0, 0);
    rst_n = 1'b1;
    wait_pulse(1'b1, e);
    check("post_reset_latency", e, 6);
    tick(4);

    // Randomised bouncing runs
    for (int r = 0; r < 400; r++) begin
      din = $urandom_range(0, 1);
      tick($urandom_range(1, 9));
    end
    din = 1'b0;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_reader.md
# button_reader

Debounced input reader for a raw board pin: a push-button or switch on the icestick headers. It synchronises the pin into the clock domain and filters contact bounce with a stability counter. It then presents a clean level plus one-cycle rise and fall pulses. It is the input-side counterpart to the counter-driven LED outputs and sits between a board input pin and the user logic in `main`.

## Interface
Parameters:
- `CNT_WIDTH`, default 20: width of the stability counter; must satisfy `STABLE - 1 < 2^CNT_WIDTH`.
- `STABLE`, default 600000: number of consecutive synchronised samples that must agree before the output level changes (50 ms at 12 MHz); minimum 2.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`, input, 1: sole clock; all state updates on its rising edge.
- `RESETN`, input, 1: asynchronous active-low reset.
- `I`, input, 1: raw, asynchronous, bouncing pin.
- `O`, output, 1: debounced level.
- `RISE`, output, 1: one-cycle pulse when `O` goes 0→1.
- `FALL`, output, 1: one-cycle pulse when `O` goes 1→0.
- `COUNT`, output, 8: number of accepted rising transitions, modulo 256.

## Operation
- **Synchroniser:** two flops, `s1` then `s2`. Only `s2` feeds the FSM.
- **Reset state:** while `RESETN`=0, `s1`, `s2`, the counter `cnt`, `O`, `RISE`, `FALL` and `COUNT` are all 0, and the state is `LOW`. Reset asserted mid-settle aborts the settle with no pulse.
- **FSM states** and transitions, each evaluated on `CLK` using pre-edge values:
  - **`LOW`:** if `s2`=1, go to `SET_HI` with `cnt`=1.
  - **`SET_HI`:**
    - if `s2`=0, go to `LOW` with `cnt`=0 and no pulse;
    - else if `cnt`==`STABLE`-1, go to `HIGH` with `O`=1, `RISE`=1 and `cnt`=0;
    - else increment `cnt`.
  - **`HIGH`:** if `s2`=0, go to `SET_LO` with `cnt`=1.
  - **`SET_LO`:**
    - if `s2`=1, go to `HIGH` with `cnt`=0 and no pulse;
    - else if `cnt`==`STABLE`-1, go to `LOW` with `O`=0, `FALL`=1 and `cnt`=0;
    - else increment `cnt`.
- **Output level:** `O` equals 1 exactly in `HIGH` and `SET_LO`.
- **Pulses:** `RISE` and `FALL` are registered and cleared on every cycle in which they are not set. They are never both 1.
- **Bounce rejection:** any single opposite sample during a settle restarts the whole settle. A glitch shorter than `STABLE` samples never changes `O`.
- **Counter width:** `cnt` never exceeds `STABLE`-1; no overflow handling is needed.
- **Press count:** `COUNT` increments in the same cycle that `RISE` is asserted. It wraps 255→0.

## Timing
- **Rise latency:** let edge k be the first rising edge at which `I`=1 is captured into `s1`, with `I` steady afterwards. `O` and `RISE` go high immediately after edge k+`STABLE`+1, i.e. on the (`STABLE`+2)th edge counting k.
- **Fall latency:** symmetric with the rise latency.
- **Pulse width:** `RISE`/`FALL` are high for exactly one cycle.
- **`COUNT` timing:** `COUNT` updates on the same edge as `RISE`.
- **`I` high across reset release:** the first edge after `RESETN` rises counts as edge k. The block emits `RISE` and increments `COUNT` after the full latency.
- **Back-to-back transitions:** the minimum spacing between a `RISE` and the following `FALL` is `STABLE` cycles.
- **Combinational paths:** none from `I` to any output; all outputs come directly from flops.

## Configuration
- **Macro:** `BUTTON_READER_COUNT_EN`.
- **Defined:** the 8-bit press counter is built and `COUNT` behaves as specified above.
- **Undefined:** no counter flops are built and `COUNT` is tied to 8'h00. All other behaviour is identical.

## Test plan
All scenarios use `STABLE`=4 and `CNT_WIDTH`=3.
- **Reset values:** hold `RESETN`=0 for 3 cycles with `I`=1 → `O`, `RISE`, `FALL` and `COUNT` are all 0 throughout.
- **Clean press:** `I` goes 0→1, first captured at edge k, and stays high → `O`=1 and `RISE`=1 after edge k+5. `RISE`=0 after edge k+6. `COUNT` goes 0→1.
- **Short glitch:** `I` high for 3 cycles, then low → `O` stays 0, no `RISE`, `COUNT` unchanged.
- **Bouncy press:** `I` pattern 1,0,1,1,0,1 followed by steady 1 → exactly one `RISE`, 6 edges after the last 0→1 capture.
- **Release and wrap:** 256 clean press/release pairs → 256 `RISE` and 256 `FALL` pulses, each one cycle wide. `COUNT` reads 0 at the end. `FALL` follows each release capture by 6 edges.
- **Reset mid-settle:** assert `RESETN`=0 while in `SET_HI` with `cnt`=2 → immediate return to `LOW` with `cnt`=0 and no pulse. After release with `I` still 1, `RISE` occurs after the full latency. With the macro undefined, `COUNT` stays 0 in every scenario.
